// File: rtl/motor_nav_pkg.sv
// Shared state encoding, motor direction codes and decode helpers for motor_nav_ctrl.
package motor_nav_pkg;

  typedef logic [2:0] state_t;

  localparam state_t STANDBY = 3'd0;
  localparam state_t FORWARD = 3'd1;
  localparam state_t RIGHT   = 3'd2;
  localparam state_t LEFT    = 3'd3;
  localparam state_t REVERSE = 3'd4;
  localparam state_t DEAD    = 3'd5;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_FWD = 2'b10;
  localparam logic [1:0] M_REV = 2'b01;

  // sensors are {front, left, right}; 000 and 011 both mean a clear path ahead
  function automatic state_t decode_target(input logic [2:0] s);
    case (s)
      3'b111:                 decode_target = REVERSE;
      3'b010, 3'b100, 3'b110: decode_target = RIGHT;
      3'b001, 3'b101:         decode_target = LEFT;
      default:                decode_target = FORWARD;
    endcase
  endfunction

  // returns {motor_a, motor_b} before PWM gating
  function automatic logic [3:0] motor_map(input state_t st);
    case (st)
      FORWARD: motor_map = {M_FWD, M_FWD};
      RIGHT:   motor_map = {M_FWD, M_REV};
      LEFT:    motor_map = {M_REV, M_FWD};
      REVERSE: motor_map = {M_REV, M_REV};
      default: motor_map = {M_OFF, M_OFF};
    endcase
  endfunction

endpackage

// File: rtl/motor_nav_ctrl_pwm_gen.sv
// Free-running PWM counter; the duty is latched only at the period boundary.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      duty_q <= '0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
      if (cnt == {PWM_BITS{1'b1}}) begin
        duty_q <= duty;
      end else begin
        duty_q <= duty_q;
      end
    end
  end

  assign pwm = (cnt < duty_q);

endmodule

// File: rtl/motor_nav_ctrl.sv
// Three-sensor navigation FSM with dwell, dead-time and PWM-gated H-bridge outputs.
// Optional SENSOR_DEBOUNCE_EN adds a DEB_CYCLES stability filter after the synchroniser.
module motor_nav_ctrl
  import motor_nav_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int MIN_DWELL   = 16,
  parameter int DEAD_CYCLES = 4,
  parameter int REV_CYCLES  = 64,
  parameter int DEB_CYCLES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [2:0]          sensors,
  input  logic                duty_ld,
  input  logic [PWM_BITS-1:0] duty_fwd,
  input  logic [PWM_BITS-1:0] duty_turn,
  output logic [1:0]          motor_a,
  output logic [1:0]          motor_b,
  output logic [2:0]          state_o,
  output logic                pwm_o
);

  localparam int DWW = $clog2(MIN_DWELL + 1);
  localparam int DCW = $clog2(DEAD_CYCLES + 1);
  localparam int RCW = $clog2(REV_CYCLES + 1);

  logic [2:0] sync1, sync2, sens;
  state_t     state, state_nx, target;
  logic [DWW-1:0] dwell_cnt;
  logic [DCW-1:0] dead_cnt;
  logic [RCW-1:0] rev_cnt;
  logic [PWM_BITS-1:0] duty_fwd_q, duty_turn_q, active_duty;
  logic       pwm;
  logic [3:0] dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= sensors;
      sync2 <= sync1;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  localparam int BW = $clog2(DEB_CYCLES + 1);
  logic [2:0] filt;

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [BW-1:0] deb_cnt;
    // a bit is accepted only after it has differed from the filtered value for DEB_CYCLES cycles
    always_ff @(posedge clk) begin
      if (reset) begin
        filt[i] <= 1'b0;
        deb_cnt <= '0;
      end else if (sync2[i] == filt[i]) begin
        filt[i] <= filt[i];
        deb_cnt <= '0;
      end else if (deb_cnt == BW'(DEB_CYCLES - 1)) begin
        filt[i] <= sync2[i];
        deb_cnt <= '0;
      end else begin
        filt[i] <= filt[i];
        deb_cnt <= deb_cnt + BW'(1);
      end
    end
  end
  assign sens = filt;
`else
  assign sens = sync2;
  // DEB_CYCLES only shapes the optional filter
  if (DEB_CYCLES < 1) begin : g_deb_unused
  end
`endif

  assign target = decode_target(sens);

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = STANDBY;
    end else begin
      case (state)
        STANDBY: state_nx = target;
        FORWARD, RIGHT, LEFT: begin
          if ((target != state) && (dwell_cnt >= DWW'(MIN_DWELL - 1))) begin
            state_nx = DEAD;
          end else begin
            state_nx = state;
          end
        end
        REVERSE: begin
          if (rev_cnt == RCW'(REV_CYCLES - 1)) begin
            state_nx = DEAD;
          end else begin
            state_nx = state;
          end
        end
        DEAD: begin
          if (dead_cnt == DCW'(DEAD_CYCLES - 1)) begin
            state_nx = target;
          end else begin
            state_nx = state;
          end
        end
        default: state_nx = STANDBY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STANDBY;
      dwell_cnt <= '0;
      dead_cnt  <= '0;
      rev_cnt   <= '0;
    end else if (state_nx != state) begin
      state     <= state_nx;
      dwell_cnt <= '0;
      dead_cnt  <= '0;
      rev_cnt   <= '0;
    end else begin
      state <= state;
      // dwell saturates at the exit threshold so long motions cannot wrap it
      if (((state == FORWARD) || (state == RIGHT) || (state == LEFT)) &&
          (dwell_cnt < DWW'(MIN_DWELL - 1))) begin
        dwell_cnt <= dwell_cnt + DWW'(1);
      end else begin
        dwell_cnt <= dwell_cnt;
      end
      dead_cnt <= (state == DEAD)    ? dead_cnt + DCW'(1) : dead_cnt;
      rev_cnt  <= (state == REVERSE) ? rev_cnt + RCW'(1)  : rev_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_fwd_q  <= '0;
      duty_turn_q <= '0;
    end else if (duty_ld) begin
      duty_fwd_q  <= duty_fwd;
      duty_turn_q <= duty_turn;
    end else begin
      duty_fwd_q  <= duty_fwd_q;
      duty_turn_q <= duty_turn_q;
    end
  end

  assign active_duty = (state == FORWARD) ? duty_fwd_q : duty_turn_q;

  pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk   (clk),
    .reset (reset),
    .duty  (active_duty),
    .pwm   (pwm)
  );

  assign dir = motor_map(state);

  always_ff @(posedge clk) begin
    if (reset) begin
      motor_a <= M_OFF;
      motor_b <= M_OFF;
      pwm_o   <= 1'b0;
    end else begin
      motor_a <= dir[3:2] & {2{pwm}};
      motor_b <= dir[1:0] & {2{pwm}};
      pwm_o   <= pwm;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_motor_nav_ctrl.sv
// Scoreboard bench for motor_nav_ctrl: a behavioural model predicts every cycle's outputs.
module tb_motor_nav_ctrl;

  localparam int MIN_DWELL   = 16;
  localparam int DEAD_CYCLES = 4;
  localparam int REV_CYCLES  = 64;
  localparam int PERIOD      = 256;

  logic       clk = 1'b0;
  logic       reset, en, duty_ld;
  logic [2:0] sensors;
  logic [7:0] duty_fwd, duty_turn;
  logic [1:0] motor_a, motor_b;
  logic [2:0] state_o;
  logic       pwm_o;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] a;
    logic [1:0] b;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  motor_nav_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sensors   (sensors),
    .duty_ld   (duty_ld),
    .duty_fwd  (duty_fwd),
    .duty_turn (duty_turn),
    .motor_a   (motor_a),
    .motor_b   (motor_b),
    .state_o   (state_o),
    .pwm_o     (pwm_o)
  );

  // target table written straight from the sensor rules: 1=FWD 2=RIGHT 3=LEFT 4=REV
  function automatic int decode(input int s);
    case (s)
      0, 3:    decode = 1;
      7:       decode = 4;
      2, 4, 6: decode = 2;
      1, 5:    decode = 3;
      default: decode = 1;
    endcase
  endfunction

  function automatic logic [3:0] dirs(input int st);
    case (st)
      1:       dirs = 4'b1010;
      2:       dirs = 4'b1001;
      3:       dirs = 4'b0110;
      4:       dirs = 4'b0101;
      default: dirs = 4'b0000;
    endcase
  endfunction

  // reference model: time-in-state counting plus a 256-cycle PWM phase
  initial begin
    int   m_state, m_time, m_cnt, m_pduty, m_dfwd, m_dturn, tgt, nxt;
    logic pwm_now;
    logic [3:0] d;
    logic [2:0] hist[$];
    exp_t e;
    m_state = 0; m_time = 0; m_cnt = 0; m_pduty = 0; m_dfwd = 0; m_dturn = 0;
    hist = '{3'b000, 3'b000};
    forever begin
      @(posedge clk);
      if (reset) begin
        m_state = 0; m_time = 0; m_cnt = 0; m_pduty = 0; m_dfwd = 0; m_dturn = 0;
        hist = '{3'b000, 3'b000};
        e = '0;
      end else begin
        pwm_now = (m_cnt < m_pduty);
        d = pwm_now ? dirs(m_state) : 4'b0000;
        tgt = decode(int'(hist[0]));
        if (!en) nxt = 0;
        else begin
          case (m_state)
            0:       nxt = tgt;
            1, 2, 3: nxt = (tgt != m_state && m_time >= MIN_DWELL - 1) ? 5 : m_state;
            4:       nxt = (m_time >= REV_CYCLES - 1) ? 5 : 4;
            5:       nxt = (m_time >= DEAD_CYCLES - 1) ? tgt : 5;
            default: nxt = 0;
          endcase
        end
        if (m_cnt == PERIOD - 1) m_pduty = (m_state == 1) ? m_dfwd : m_dturn;
        m_cnt = (m_cnt + 1) % PERIOD;
        if (duty_ld) begin
          m_dfwd  = int'(duty_fwd);
          m_dturn = int'(duty_turn);
        end
        void'(hist.pop_front());
        hist.push_back(sensors);
        m_time  = (nxt != m_state) ? 0 : m_time + 1;
        m_state = nxt;
        e.st = 3'(m_state);
        e.a  = d[3:2];
        e.b  = d[1:0];
        e.p  = pwm_now;
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // monitor: compares one predicted record per cycle, away from the active edge
  initial begin
    exp_t e;
    bit   started = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        started = 1'b1;
        e = exp_q.pop_front();
        chk("state_o", int'(state_o), int'(e.st));
        chk("motor_a", int'(motor_a), int'(e.a));
        chk("motor_b", int'(motor_b), int'(e.b));
        chk("pwm_o",   int'(pwm_o),   int'(e.p));
        if (motor_a == 2'b11 || motor_b == 2'b11) begin
          errors++;
          $display("FAIL shoot_through got a=%b b=%b expected no 11", motor_a, motor_b);
        end
      end else if (started) begin
        chk("scoreboard_empty", 0, 1);
      end
    end
  end

  task automatic run(input logic e_in, input logic [2:0] s, input int n);
    en = e_in;
    sensors = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] f, input logic [7:0] t);
    duty_fwd  = f;
    duty_turn = t;
    duty_ld   = 1'b1;
    @(negedge clk);
    duty_ld   = 1'b0;
  endtask

  function automatic logic [7:0] pick_duty();
    case ($urandom_range(0, 4))
      0:       pick_duty = 8'd0;
      1:       pick_duty = 8'd255;
      default: pick_duty = 8'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; sensors = 3'b000; duty_ld = 1'b0;
    duty_fwd = 8'd0; duty_turn = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    load(8'd128, 8'd64);
    run(1'b1, 3'b000, 600);
    run(1'b1, 3'b000, 5);
    run(1'b1, 3'b010, 300);
    run(1'b1, 3'b000, 100);
    run(1'b1, 3'b111, 200);
    run(1'b1, 3'b000, 150);
    repeat (50) @(negedge clk);
    load(8'd200, 8'd90);
    run(1'b1, 3'b000, 600);
    load(8'd0, 8'd255);
    run(1'b1, 3'b000, 300);
    run(1'b1, 3'b001, 300);
    run(1'b0, 3'b001, 3);
    run(1'b1, 3'b110, 60);
    run(1'b1, 3'b111, 50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load(8'd77, 8'd180);
    for (int ph = 0; ph < 300; ph++) begin
      int hold;
      sensors = 3'($urandom_range(0, 7));
      en      = ($urandom_range(0, 15) != 0);
      hold    = $urandom_range(1, 80);
      for (int c = 0; c < hold; c++) begin
        duty_ld   = ($urandom_range(0, 150) == 0);
        duty_fwd  = pick_duty();
        duty_turn = pick_duty();
        reset     = ($urandom_range(0, 3000) == 0);
        @(negedge clk);
      end
    end
    duty_ld = 1'b0;
    reset   = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
